// File: rtl/led_pkg.sv
// Shared encodings for the LED chaser and the display blocks that follow it.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_ROT_UP = 2'b01,
    MODE_ROT_DN = 2'b10,
    MODE_BAR    = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable step prescaler: asserts step once every PERIOD+1 enabled cycles.
module tick_prescaler #(
  parameter int unsigned PRESCALE_W = 24
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  ENABLE,
  input  logic [PRESCALE_W-1:0] PERIOD,
  output logic                  step
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // A PERIOD lowered below cnt is not special-cased; cnt simply wraps around.
  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (ENABLE) begin
      if (cnt_q == PERIOD) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_chaser_param.sv
// N-wide LED sequencer: bounce, rotate up/down or bar-fill, stepped by a prescaler tick.
module led_chaser_param
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS     = 8,
  parameter int unsigned PRESCALE_W = 24,
  parameter int unsigned POS_W      = $clog2(N_LEDS)
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  ENABLE,
  input  logic [1:0]            MODE,
  input  logic [PRESCALE_W-1:0] PERIOD,
  output logic [N_LEDS-1:0]     LEDG,
  output logic [POS_W-1:0]      POS,
  output logic                  DIR,
  output logic                  TICK
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

  mode_e                mode;
  logic                 step;
  logic [POS_W-1:0]     pos_q, pos_d;
  dir_e                 dir_q, dir_d;
  logic                 tick_q, tick_d;
  logic [N_LEDS-1:0]    ledg_q, ledg_d;

  assign mode = mode_e'(MODE);

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .ENABLE (ENABLE),
    .PERIOD (PERIOD),
    .step   (step)
  );

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    ledg_d = ledg_q;
    tick_d = step;
    if (step) begin
      unique case (mode)
        MODE_BOUNCE: begin
          // Direction is inherited across mode changes, so a turn can happen on entry.
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              pos_d = POS_LAST - POS_W'(1);
              dir_d = DIR_DN;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = POS_W'(1);
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        MODE_ROT_DN: begin
          pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
          dir_d = DIR_DN;
        end
        default: begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
          dir_d = DIR_UP;
        end
      endcase
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        ledg_d[i] = (mode == MODE_BAR) ? (POS_W'(i) <= pos_d) : (POS_W'(i) == pos_d);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      tick_q <= 1'b0;
      ledg_q <= N_LEDS'(1);
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      ledg_q <= ledg_d;
    end
  end

  assign LEDG = ledg_q;
  assign POS  = pos_q;
  assign DIR  = dir_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_chaser_param.sv
// Bench for led_chaser_param: three widths (8, 2, 13) driven in parallel against a step-rule model.
module tb_led_chaser_param;

  logic        CLK;
  logic        RSTn;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] period;

  logic [7:0]  led0;  logic [2:0] pos0; logic dir0; logic tick0;
  logic [1:0]  led1;  logic [0:0] pos1; logic dir1; logic tick1;
  logic [12:0] led2;  logic [3:0] pos2; logic dir2; logic tick2;

  led_chaser_param #(.N_LEDS(8), .PRESCALE_W(24)) dut8 (
    .CLK(CLK), .RSTn(RSTn), .ENABLE(en), .MODE(mode), .PERIOD(period),
    .LEDG(led0), .POS(pos0), .DIR(dir0), .TICK(tick0));
  led_chaser_param #(.N_LEDS(2), .PRESCALE_W(24)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .ENABLE(en), .MODE(mode), .PERIOD(period),
    .LEDG(led1), .POS(pos1), .DIR(dir1), .TICK(tick1));
  led_chaser_param #(.N_LEDS(13), .PRESCALE_W(24)) dut13 (
    .CLK(CLK), .RSTn(RSTn), .ENABLE(en), .MODE(mode), .PERIOD(period),
    .LEDG(led2), .POS(pos2), .DIR(dir2), .TICK(tick2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [63:0] d_led[3], d_pos[3], d_dir[3], d_tick[3];
  always_comb begin
    d_led[0] = 64'(led0); d_pos[0] = 64'(pos0); d_dir[0] = 64'(dir0); d_tick[0] = 64'(tick0);
    d_led[1] = 64'(led1); d_pos[1] = 64'(pos1); d_dir[1] = 64'(dir1); d_tick[1] = 64'(tick1);
    d_led[2] = 64'(led2); d_pos[2] = 64'(pos2); d_dir[2] = 64'(dir2); d_tick[2] = 64'(tick2);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: position/direction as integers, pattern as shifted masks.
  int          n_of[3] = '{8, 2, 13};
  int          m_pos[3];
  bit          m_dir[3];
  logic [63:0] m_led[3];
  bit          m_tick;
  logic [23:0] m_cnt;

  task automatic model_reset();
    m_cnt  = '0;
    m_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = 0; m_dir[i] = 1'b0; m_led[i] = 64'd1;
    end
  endtask

  task automatic model_edge();
    bit st;
    int n;
    st = en && (m_cnt == period);
    if (en) m_cnt = st ? 24'd0 : m_cnt + 24'd1;
    m_tick = st;
    if (st) begin
      for (int i = 0; i < 3; i++) begin
        n = n_of[i];
        case (mode)
          2'd0: begin
            if (!m_dir[i]) begin
              if (m_pos[i] == n - 1) begin m_pos[i] = n - 2; m_dir[i] = 1'b1; end
              else m_pos[i] = m_pos[i] + 1;
            end else begin
              if (m_pos[i] == 0) begin m_pos[i] = 1; m_dir[i] = 1'b0; end
              else m_pos[i] = m_pos[i] - 1;
            end
          end
          2'd2:    begin m_pos[i] = (m_pos[i] + n - 1) % n; m_dir[i] = 1'b1; end
          default: begin m_pos[i] = (m_pos[i] + 1) % n;     m_dir[i] = 1'b0; end
        endcase
        m_led[i] = (mode == 2'd3) ? ((64'd2 << m_pos[i]) - 64'd1) : (64'd1 << m_pos[i]);
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model n%0d ledg", n_of[i]), d_led[i], m_led[i]);
      chk($sformatf("model n%0d pos", n_of[i]), d_pos[i], 64'(m_pos[i]));
      chk($sformatf("model n%0d dir", n_of[i]), d_dir[i], 64'(m_dir[i]));
      chk($sformatf("model n%0d tick", n_of[i]), d_tick[i], 64'(m_tick));
      chk($sformatf("range n%0d pos<n", n_of[i]), 64'(d_pos[i] < 64'(n_of[i])), 64'd1);
    end
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    model_reset();
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    logic [1:0]  mode;
    logic [23:0] period;
    int          pos;
    bit          dir;
    bit          tick;
    logic [7:0]  led;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit e, logic [1:0] md, logic [23:0] per,
                              int p, bit d, bit t, logic [7:0] l);
    vec_t v;
    v.rst = rst; v.en = e; v.mode = md; v.period = per;
    v.pos = p; v.dir = d; v.tick = t; v.led = l;
    vecs.push_back(v);
  endfunction

  initial begin
    int          bpos[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    bit          bdir[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [7:0]  one8;
    logic [7:0]  held;
    logic [23:0] np;

    RSTn = 1'b0; en = 1'b1; mode = 2'd0; period = '0;
    model_reset();
    #12;
    chk("reset ledg", d_led[0], 64'h01);
    chk("reset pos", d_pos[0], 64'd0);
    chk("reset dir", d_dir[0], 64'd0);
    chk("reset tick", d_tick[0], 64'd0);

    // Directed vectors on the 8-LED instance.
    one8 = 8'h01;
    for (int k = 0; k < 16; k++)
      add(k == 0, 1'b1, 2'd0, 24'd0, bpos[k], bdir[k], 1'b1, one8 << bpos[k]);
    for (int k = 1; k <= 12; k++)
      add(k == 1, 1'b1, 2'd1, 24'd3, k / 4, 1'b0, (k % 4) == 0, one8 << (k / 4));
    add(1, 1, 2'd2, 24'd0, 7, 1, 1, 8'h80);
    add(0, 1, 2'd2, 24'd0, 6, 1, 1, 8'h40);
    add(0, 1, 2'd2, 24'd0, 5, 1, 1, 8'h20);
    add(1, 1, 2'd3, 24'd0, 1, 0, 1, 8'h03);
    add(0, 1, 2'd3, 24'd0, 2, 0, 1, 8'h07);
    add(0, 1, 2'd3, 24'd0, 3, 0, 1, 8'h0F);
    add(0, 1, 2'd3, 24'd0, 4, 0, 1, 8'h1F);
    add(0, 1, 2'd3, 24'd0, 5, 0, 1, 8'h3F);
    add(0, 1, 2'd3, 24'd0, 6, 0, 1, 8'h7F);
    add(0, 1, 2'd3, 24'd0, 7, 0, 1, 8'hFF);
    add(0, 1, 2'd3, 24'd0, 0, 0, 1, 8'h01);

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) do_reset();
      en = vecs[k].en; mode = vecs[k].mode; period = vecs[k].period;
      cycle();
      chk($sformatf("vec%0d pos", k), d_pos[0], 64'(vecs[k].pos));
      chk($sformatf("vec%0d dir", k), d_dir[0], 64'(vecs[k].dir));
      chk($sformatf("vec%0d tick", k), d_tick[0], 64'(vecs[k].tick));
      chk($sformatf("vec%0d ledg", k), d_led[0], 64'(vecs[k].led));
    end

    // Freeze with cnt=3 of PERIOD=5: resume must tick on the third enabled edge.
    do_reset();
    en = 1'b1; mode = 2'd1; period = 24'd5;
    for (int k = 0; k < 3; k++) cycle();
    held = led0;
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("freeze tick", d_tick[0], 64'd0);
      chk("freeze ledg", d_led[0], 64'(held));
    end
    en = 1'b1;
    cycle(); chk("resume tick+1", d_tick[0], 64'd0);
    cycle(); chk("resume tick+2", d_tick[0], 64'd0);
    cycle(); chk("resume tick+3", d_tick[0], 64'd1);
    chk("resume ledg", d_led[0], 64'h02);

    // Asynchronous reset between edges at POS=5 going down.
    do_reset();
    en = 1'b1; mode = 2'd0; period = 24'd0;
    for (int k = 0; k < 9; k++) cycle();
    chk("pre-rst pos", d_pos[0], 64'd5);
    chk("pre-rst dir", d_dir[0], 64'd1);
    @(negedge CLK);
    #1 RSTn = 1'b0;
    #1;
    chk("async rst ledg", d_led[0], 64'h01);
    chk("async rst pos", d_pos[0], 64'd0);
    chk("async rst dir", d_dir[0], 64'd0);
    chk("async rst tick", d_tick[0], 64'd0);
    model_reset();
    #1 RSTn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk("n2 bounce alt", d_pos[1], 64'(k % 2));
    end

    // Rotate-up wrap on the 13-LED instance.
    do_reset();
    mode = 2'd1;
    for (int k = 1; k <= 14; k++) begin
      cycle();
      chk("n13 rot pos", d_pos[2], 64'(k % 13));
    end

    // Randomized run: mode/enable/period changes and occasional async reset.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        np = 24'($urandom_range(0, 4));
        if (np >= m_cnt) period = np;
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
